// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver types, constants and baud helper
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;

  // Integer clocks per bit; the receiver samples on these boundaries.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - generic asynchronous-reset flop chain for async input pins
module bit_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw pin through the chain; reset presets every stage to the idle level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 UART receiver with ready/ack byte handshake and error flags
module uart_rx_core import uart_pkg::*; #(
  parameter int CLK_HZ       = 12_000_000,
  parameter int BAUD         = 115_200,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD),
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      rx,
  input  logic                      rx_data_ack,
  input  logic                      rx_err_clr,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_data_ready,
  output logic                      rx_frame_err,
  output logic                      rx_overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_cpb
    $error("uart_rx_core: CLKS_PER_BIT must be >= 4");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("uart_rx_core: SYNC_STAGES must be >= 2");
  end

  logic rx_s;

  uart_rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                      frame_err_q, frame_err_d;
  logic                      deliver;

  logic [UART_DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                      ready_q, ready_d;
  logic                      overrun_q, overrun_d;
  logic                      take;

  bit_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    (rx),
    .q_o    (rx_s)
  );

  // Receiver state register: state, bit timer, bit index, shift register, frame error pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state logic: the bit timer free-runs within a state and clears on every transition.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    deliver     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
        end
      end
      DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d     = '0;
          shreg_d   = {rx_s, shreg_q[UART_DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
            deliver = 1'b1;
          end else begin
            state_d     = BREAK;
            frame_err_d = 1'b1;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        bit_idx_d = '0;
      end
    endcase
  end

  assign take = !ready_q || rx_data_ack;

  // Handshake next-state: a delivery beats a same-cycle ack; a new overrun beats a clear.
  always_comb begin
    rx_data_d = rx_data_q;
    ready_d   = ready_q;
    overrun_d = overrun_q;
    if (deliver && take) begin
      rx_data_d = shreg_q;
      ready_d   = 1'b1;
    end else if (ready_q && rx_data_ack) begin
      ready_d = 1'b0;
    end
    if (deliver && !take) begin
      overrun_d = 1'b1;
    end else if (rx_err_clr) begin
      overrun_d = 1'b0;
    end
  end

  // Output/handshake registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data_q <= '0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      rx_data_q <= rx_data_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_data_ready = ready_q;
  assign rx_frame_err  = frame_err_q;
  assign rx_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - self-checking bench for uart_rx_core with a frame-level model
module tb_uart_rx_core;

  localparam int F    = 16;
  localparam int HALF = F / 2;
  localparam int SYNC = 2;
  // Line fall to stop-sample edge: sync + start entry, half bit, eight data bits, stop bit.
  localparam int LAT  = SYNC + 1 + HALF + 9 * F;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_data_ack = 1'b0;
  logic       rx_err_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_data_ready;
  logic       rx_frame_err;
  logic       rx_overrun;

  always #5 clk = ~clk;

  uart_rx_core #(
    .CLK_HZ       (1_843_200),
    .BAUD         (115_200),
    .CLKS_PER_BIT (F),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rx            (rx),
    .rx_data_ack   (rx_data_ack),
    .rx_err_clr    (rx_err_clr),
    .rx_data       (rx_data),
    .rx_data_ready (rx_data_ready),
    .rx_frame_err  (rx_frame_err),
    .rx_overrun    (rx_overrun)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Expected frame outcomes, each tagged with the clock edge at which its stop bit is judged.
  int         ev_cyc [128];
  logic [7:0] ev_dat [128];
  bit         ev_ok  [128];
  int         ev_head = 0;
  int         ev_tail = 0;
  logic       ev_hit;
  logic       ev_dlv;
  logic       ev_ferr;

  assign ev_hit  = (ev_head != ev_tail) && (ev_cyc[ev_head] == cyc + 1);
  assign ev_dlv  = ev_hit && ev_ok[ev_head];
  assign ev_ferr = ev_hit && !ev_ok[ev_head];

  logic       m_ready = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_ferr = 1'b0;
  logic       m_ovr = 1'b0;

  // Consumer-side model: what the outputs must be given frame outcomes and ack/clear inputs.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ready <= 1'b0;
      m_data  <= 8'h00;
      m_ferr  <= 1'b0;
      m_ovr   <= 1'b0;
      ev_head <= ev_tail;
    end else begin
      if (ev_hit) ev_head <= ev_head + 1;
      m_ferr <= ev_ferr;
      if (ev_dlv && (!m_ready || rx_data_ack)) begin
        m_data  <= ev_dat[ev_head];
        m_ready <= 1'b1;
      end else if (!ev_dlv && m_ready && rx_data_ack) begin
        m_ready <= 1'b0;
      end
      if (ev_dlv && m_ready && !rx_data_ack) m_ovr <= 1'b1;
      else if (rx_err_clr) m_ovr <= 1'b0;
    end
  end

  logic       p_ready = 1'b0;
  logic       p_ack = 1'b0;
  logic       p_ferr = 1'b0;
  logic [7:0] p_data = 8'h00;
  int         ferr_cnt = 0;
  int         rises = 0;

  // Per-cycle comparison against the model plus the two line-level invariants.
  always @(negedge clk) begin
    chk("rx_data_ready", {31'b0, rx_data_ready}, {31'b0, m_ready});
    chk("rx_data", {24'b0, rx_data}, {24'b0, m_data});
    chk("rx_frame_err", {31'b0, rx_frame_err}, {31'b0, m_ferr});
    chk("rx_overrun", {31'b0, rx_overrun}, {31'b0, m_ovr});
    if (reset_n && p_ready && !p_ack) chk("data_stable", {24'b0, rx_data}, {24'b0, p_data});
    if (p_ferr) chk("ferr_single_cycle", {31'b0, rx_frame_err}, 32'd0);
    if (rx_frame_err) ferr_cnt <= ferr_cnt + 1;
    if (rx_data_ready && !p_ready) rises <= rises + 1;
    p_ready <= rx_data_ready;
    p_ack   <= rx_data_ack;
    p_ferr  <= rx_frame_err;
    p_data  <= rx_data;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit ok, input int hold);
    ev_cyc[ev_tail] = cyc + LAT;
    ev_dat[ev_tail] = b;
    ev_ok[ev_tail]  = ok;
    ev_tail = ev_tail + 1;
    rx = 1'b0;
    tick(F);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(F);
    end
    rx = ok;
    tick(F);
    if (hold > 0) tick(hold);
    rx = 1'b1;
  endtask

  task automatic ack_pulse();
    rx_data_ack = 1'b1;
    tick(1);
    rx_data_ack = 1'b0;
  endtask

  logic [7:0] rb;
  bit         rok;
  bit         rnd_done = 1'b0;
  bit         seen;
  int         n0;
  int         f0;
  int         r0;
  logic [7:0] pb;

  initial begin
    tick(3);
    chk("reset_ready", {31'b0, rx_data_ready}, 32'd0);
    chk("reset_data", {24'b0, rx_data}, 32'd0);
    chk("reset_ferr", {31'b0, rx_frame_err}, 32'd0);
    chk("reset_ovr", {31'b0, rx_overrun}, 32'd0);
    reset_n = 1'b1;
    tick(2 * F);

    // 1: single byte, ack one cycle after ready
    n0 = cyc;
    fork
      send_frame(8'hA5, 1'b1, 0);
      begin
        seen = 1'b0;
        for (int k = 0; k < 12 * F; k++) begin
          tick(1);
          if (rx_data_ready) begin
            seen = 1'b1;
            break;
          end
        end
        chk("t1_ready_seen", {31'b0, seen}, 32'd1);
        chk("t1_latency", cyc - n0, 32'd155);
        chk("t1_data", {24'b0, rx_data}, 32'h0000_00A5);
        tick(1);
        chk("t1_ready_held", {31'b0, rx_data_ready}, 32'd1);
        ack_pulse();
        chk("t1_ready_dropped", {31'b0, rx_data_ready}, 32'd0);
      end
    join
    tick(F);

    // 2: back-to-back bytes with ack held high
    f0 = ferr_cnt;
    r0 = rises;
    rx_data_ack = 1'b1;
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    send_frame(8'h55, 1'b1, 0);
    tick(F);
    rx_data_ack = 1'b0;
    chk("t2_deliveries", rises - r0, 32'd3);
    chk("t2_last_data", {24'b0, rx_data}, 32'h0000_0055);
    chk("t2_no_ferr", ferr_cnt - f0, 32'd0);
    chk("t2_no_ovr", {31'b0, rx_overrun}, 32'd0);

    // 3: short glitch on idle line
    r0 = rises;
    rx = 1'b0;
    tick(6);
    rx = 1'b1;
    tick(12 * F);
    chk("t3_no_delivery", rises - r0, 32'd0);
    chk("t3_no_ferr", ferr_cnt - f0, 32'd0);

    // 4: bad stop bit then a long break, then a good frame
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 40 * F);
    tick(2 * F);
    chk("t4_one_ferr", ferr_cnt - f0, 32'd1);
    chk("t4_no_ready", {31'b0, rx_data_ready}, 32'd0);
    send_frame(8'h3C, 1'b1, 0);
    tick(F);
    chk("t4_ready", {31'b0, rx_data_ready}, 32'd1);
    chk("t4_data", {24'b0, rx_data}, 32'h0000_003C);
    ack_pulse();

    // 5: overrun, then clear
    send_frame(8'h11, 1'b1, 0);
    tick(F);
    send_frame(8'h22, 1'b1, 0);
    tick(F);
    chk("t5_data_kept", {24'b0, rx_data}, 32'h0000_0011);
    chk("t5_overrun", {31'b0, rx_overrun}, 32'd1);
    rx_err_clr = 1'b1;
    tick(1);
    rx_err_clr = 1'b0;
    chk("t5_overrun_clr", {31'b0, rx_overrun}, 32'd0);
    ack_pulse();
    tick(F);

    // 6: reset in the middle of data bit 4, then a clean frame
    pb = 8'h96;
    rx = 1'b0;
    tick(F);
    for (int i = 0; i < 4; i++) begin
      rx = pb[i];
      tick(F);
    end
    rx = pb[4];
    tick(HALF);
    reset_n = 1'b0;
    tick(1);
    chk("t6_rst_ready", {31'b0, rx_data_ready}, 32'd0);
    chk("t6_rst_data", {24'b0, rx_data}, 32'd0);
    chk("t6_rst_ovr", {31'b0, rx_overrun}, 32'd0);
    tick(4);
    rx = 1'b1;
    tick(1);
    reset_n = 1'b1;
    tick(2 * F);
    chk("t6_no_partial", {31'b0, rx_data_ready}, 32'd0);
    send_frame(8'h7E, 1'b1, 0);
    tick(F);
    chk("t6_data", {24'b0, rx_data}, 32'h0000_007E);
    chk("t6_ready", {31'b0, rx_data_ready}, 32'd1);
    ack_pulse();
    tick(F);

    // Randomized frames with a sparse random consumer
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          rb  = 8'($urandom);
          rok = ($urandom_range(0, 7) != 0);
          send_frame(rb, rok, 0);
          if (!rok) tick(F);
          else tick($urandom_range(0, F));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          rx_data_ack = ($urandom_range(0, 255) == 0);
          rx_err_clr  = ($urandom_range(0, 63) == 0);
          tick(1);
        end
      end
    join
    rx_data_ack = 1'b0;
    rx_err_clr  = 1'b0;
    tick(2 * F);
    chk("all_events_consumed", ev_tail - ev_head, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
